// File: rtl/avalon_button_led_pio.sv
// avalon_button_led_pio: Avalon-MM pushbutton debounce/edge-capture/irq plus hex/LED output register.
// Ports: clk, reset (async, active-high); avs_* word-addressed slave with fixed read latency 1;
// pushbutton_in raw pins; to_hex_to_led output register; irq level interrupt.
module avalon_button_led_pio #(
  parameter int          N_BUTTONS         = 4,
  parameter int          OUT_WIDTH         = 32,
  parameter int          DEBOUNCE_CYCLES   = 50000,
  parameter int          BUTTON_ACTIVE_LOW = 1,
  parameter int          EDGE_MODE         = 0,
  parameter logic [31:0] OUT_RESET_VALUE   = 32'h0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  input  logic [3:0]           avs_byteenable,
  output logic [31:0]          avs_readdata,
  input  logic [N_BUTTONS-1:0] pushbutton_in,
  output logic [OUT_WIDTH-1:0] to_hex_to_led,
  output logic                 irq
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [N_BUTTONS-1:0] sync1_q, sync2_q, deb_q, deb_d, prev_q, mask_q, mask_d, cap_q, cap_d;
  logic [N_BUTTONS-1:0] pressed, edges, clr;
  logic [CW-1:0] cnt_q [N_BUTTONS];
  logic [CW-1:0] cnt_d [N_BUTTONS];
  logic [OUT_WIDTH-1:0] out_q, out_d;
  logic [31:0] rdata_q, rdata_d, be_mask, out_ext, out_nxt, rsel;
  logic irq_q, irq_d;
  logic wr_mask, wr_cap, wr_out, wr_set, wr_clr;
  assign be_mask = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}}, {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
  assign wr_mask = avs_write && avs_address == 3'd1;
  assign wr_cap  = avs_write && avs_address == 3'd2;
  assign wr_out  = avs_write && avs_address == 3'd3;
  assign wr_set  = avs_write && avs_address == 3'd4;
  assign wr_clr  = avs_write && avs_address == 3'd5;
  assign pressed = BUTTON_ACTIVE_LOW != 0 ? ~sync2_q : sync2_q;
  // prev_q lags deb_q by one cycle, so captures land one cycle after the level change
  assign edges = EDGE_MODE == 0 ? deb_q & ~prev_q : EDGE_MODE == 1 ? ~deb_q & prev_q : deb_q ^ prev_q;
  assign clr = wr_cap ? N_BUTTONS'(avs_writedata & be_mask) : '0;
  assign out_ext = 32'(out_q);
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < N_BUTTONS; i++) begin
      if (pressed[i] == deb_q[i]) cnt_d[i] = '0;
      else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = pressed[i];
        cnt_d[i] = '0;
      end else cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end
  always_comb begin
    mask_d  = wr_mask ? (mask_q & ~N_BUTTONS'(be_mask)) | N_BUTTONS'(avs_writedata & be_mask) : mask_q;
    cap_d   = (cap_q & ~clr) | edges;
    irq_d   = |(cap_q & mask_q);
    out_nxt = wr_out ? (out_ext & ~be_mask) | (avs_writedata & be_mask) :
              wr_set ? out_ext | avs_writedata :
              wr_clr ? out_ext & ~avs_writedata : out_ext;
    out_d   = OUT_WIDTH'(out_nxt);
    rsel    = avs_address == 3'd0 ? 32'(deb_q) :
              avs_address == 3'd1 ? 32'(mask_q) :
              avs_address == 3'd2 ? 32'(cap_q) :
              avs_address == 3'd3 ? out_ext : 32'h0;
    rdata_d = avs_read ? rsel : rdata_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      prev_q  <= '0;
      cnt_q   <= '{default: '0};
      mask_q  <= '0;
      cap_q   <= '0;
      irq_q   <= 1'b0;
      out_q   <= OUT_WIDTH'(OUT_RESET_VALUE);
      rdata_q <= '0;
    end else begin
      sync1_q <= pushbutton_in;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      prev_q  <= deb_q;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      irq_q   <= irq_d;
      out_q   <= out_d;
      rdata_q <= rdata_d;
    end
  end
  assign avs_readdata  = rdata_q;
  assign to_hex_to_led = out_q;
  assign irq           = irq_q;
endmodule

// File: tb/tb_avalon_button_led_pio.sv
// tb_avalon_button_led_pio: directed, table-driven and randomized model checks of avalon_button_led_pio.
module tb_avalon_button_led_pio;
  localparam int D = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic [2:0] addr = '0;
  logic rd = 1'b0, wr = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0] be = '0, pb = 4'hF;
  logic [31:0] out0, out1, out2, rd0, rd1, rd2;
  logic irq0, irq1, irq2;
  int n_run = 0, n_fail = 0;
  bit mchk = 1'b0;
  logic [3:0] m_d1, m_d2, m_lvl, m_pend, m_cap, m_mask;
  logic [3:0] m_win [D];
  logic [31:0] m_out, m_rd;
  logic m_irq;
  typedef struct {
    logic [2:0] a; logic w; logic r; logic [31:0] d; logic [3:0] b; logic [31:0] eo; logic [31:0] er;
  } vec_t;
  vec_t tbl [19];
  always #5 clk = ~clk;
  avalon_button_led_pio #(.DEBOUNCE_CYCLES(D), .EDGE_MODE(0)) u0 (.clk(clk), .reset(reset), .avs_address(addr),
    .avs_read(rd), .avs_write(wr), .avs_writedata(wdata), .avs_byteenable(be), .avs_readdata(rd0),
    .pushbutton_in(pb), .to_hex_to_led(out0), .irq(irq0));
  avalon_button_led_pio #(.DEBOUNCE_CYCLES(D), .EDGE_MODE(1)) u1 (.clk(clk), .reset(reset), .avs_address(addr),
    .avs_read(rd), .avs_write(wr), .avs_writedata(wdata), .avs_byteenable(be), .avs_readdata(rd1),
    .pushbutton_in(pb), .to_hex_to_led(out1), .irq(irq1));
  avalon_button_led_pio #(.DEBOUNCE_CYCLES(D), .EDGE_MODE(2)) u2 (.clk(clk), .reset(reset), .avs_address(addr),
    .avs_read(rd), .avs_write(wr), .avs_writedata(wdata), .avs_byteenable(be), .avs_readdata(rd2),
    .pushbutton_in(pb), .to_hex_to_led(out2), .irq(irq2));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic mreset();
    m_d1 = '0; m_d2 = '0; m_lvl = '0; m_pend = '0; m_cap = '0; m_mask = '0;
    m_out = '0; m_rd = '0; m_irq = 1'b0;
    for (int j = 0; j < D; j++) m_win[j] = '0;
  endtask
  // Debounced level flips once the last D synchronised samples all disagree with it.
  task automatic mstep();
    logic [3:0] nl;
    bit all;
    if (reset) begin
      mreset();
      return;
    end
    for (int j = 0; j < D - 1; j++) m_win[j] = m_win[j + 1];
    m_win[D - 1] = ~m_d2;
    nl = m_lvl;
    for (int b = 0; b < 4; b++) begin
      all = 1'b1;
      for (int j = 0; j < D; j++) if (m_win[j][b] == m_lvl[b]) all = 1'b0;
      if (all) nl[b] = ~m_lvl[b];
    end
    if (rd) m_rd = addr == 0 ? {28'h0, m_lvl} : addr == 1 ? {28'h0, m_mask} :
                   addr == 2 ? {28'h0, m_cap} : addr == 3 ? m_out : 32'h0;
    m_irq = |(m_cap & m_mask);
    m_cap = (m_cap & ~((wr && addr == 2 && be[0]) ? wdata[3:0] : 4'h0)) | m_pend;
    m_pend = nl & ~m_lvl;
    m_lvl = nl;
    if (wr && addr == 1 && be[0]) m_mask = wdata[3:0];
    if (wr && addr == 3) begin
      for (int i = 0; i < 4; i++) if (be[i]) m_out[8*i +: 8] = wdata[8*i +: 8];
    end else if (wr && addr == 4) m_out = m_out | wdata;
    else if (wr && addr == 5) m_out = m_out & ~wdata;
    m_d2 = m_d1;
    m_d1 = pb;
  endtask
  task automatic tick();
    @(posedge clk);
    mstep();
    @(negedge clk);
    if (mchk) begin
      chk("model_out", out0, m_out);
      chk("model_irq", {31'h0, irq0}, {31'h0, m_irq});
      chk("model_rdata", rd0, m_rd);
    end
  endtask
  task automatic idle(input int k);
    repeat (k) tick();
  endtask
  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a; wdata = d; be = b; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask
  task automatic bus_rd(input logic [2:0] a);
    addr = a; rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask
  initial begin
    int k;
    tbl[0]  = '{3'd7, 1'b0, 1'b1, 32'h0,        4'h0, 32'h00000000, 32'h00000000};
    tbl[1]  = '{3'd3, 1'b1, 1'b0, 32'h12345678, 4'h4, 32'h00340000, 32'h00000000};
    tbl[2]  = '{3'd4, 1'b1, 1'b0, 32'h0000000F, 4'h0, 32'h0034000F, 32'h00000000};
    tbl[3]  = '{3'd5, 1'b1, 1'b0, 32'h00300000, 4'h0, 32'h0004000F, 32'h00000000};
    tbl[4]  = '{3'd3, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0004000F, 32'h0004000F};
    tbl[5]  = '{3'd4, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0004000F, 32'h00000000};
    tbl[6]  = '{3'd5, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0004000F, 32'h00000000};
    tbl[7]  = '{3'd6, 1'b1, 1'b0, 32'hFFFFFFFF, 4'hF, 32'h0004000F, 32'h00000000};
    tbl[8]  = '{3'd0, 1'b1, 1'b0, 32'hFFFFFFFF, 4'hF, 32'h0004000F, 32'h00000000};
    tbl[9]  = '{3'd3, 1'b1, 1'b1, 32'hAAAAAAAA, 4'hF, 32'hAAAAAAAA, 32'h0004000F};
    tbl[10] = '{3'd3, 1'b0, 1'b1, 32'h0,        4'h0, 32'hAAAAAAAA, 32'hAAAAAAAA};
    tbl[11] = '{3'd3, 1'b1, 1'b0, 32'hFFFFFFFF, 4'h3, 32'hAAAAFFFF, 32'hAAAAAAAA};
    tbl[12] = '{3'd1, 1'b1, 1'b0, 32'hFFFFFFFF, 4'hE, 32'hAAAAFFFF, 32'hAAAAAAAA};
    tbl[13] = '{3'd1, 1'b0, 1'b1, 32'h0,        4'h0, 32'hAAAAFFFF, 32'h00000000};
    tbl[14] = '{3'd1, 1'b1, 1'b0, 32'hFFFFFFFF, 4'h1, 32'hAAAAFFFF, 32'h00000000};
    tbl[15] = '{3'd1, 1'b0, 1'b1, 32'h0,        4'h0, 32'hAAAAFFFF, 32'h0000000F};
    tbl[16] = '{3'd1, 1'b1, 1'b0, 32'h00000002, 4'hF, 32'hAAAAFFFF, 32'h0000000F};
    tbl[17] = '{3'd0, 1'b0, 1'b1, 32'h0,        4'h0, 32'hAAAAFFFF, 32'h00000002};
    tbl[18] = '{3'd3, 1'b1, 1'b0, 32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF, 32'h00000002};
    mreset();
    idle(2);
    chk("rst_out", out0, 32'h0);
    chk("rst_irq", {31'h0, irq0}, 32'h0);
    chk("rst_rdata", rd0, 32'h0);
    reset = 1'b0;
    idle(8);
    bus_rd(0); chk("idle_data", rd0, 32'h0);
    bus_rd(2); chk("idle_cap", rd0, 32'h0);
    chk("idle_irq", {31'h0, irq0}, 32'h0);
    pb[1] = 1'b0; idle(3); pb[1] = 1'b1; idle(10);
    bus_rd(0); chk("glitch_data", rd0, 32'h0);
    bus_rd(2); chk("glitch_cap", rd0, 32'h0);
    addr = 3'd0; rd = 1'b1; pb[1] = 1'b0;
    idle(6); chk("deb_before", rd0, 32'h0);
    tick(); chk("deb_at6", rd0, 32'h2);
    addr = 3'd2; tick(); rd = 1'b0;
    chk("press_cap", rd0, 32'h2);
    chk("press_irq_masked", {31'h0, irq0}, 32'h0);
    bus_wr(1, 32'h2, 4'hF); chk("mask_irq_pre", {31'h0, irq0}, 32'h0);
    tick(); chk("mask_irq_post", {31'h0, irq0}, 32'h1);
    bus_wr(2, 32'h2, 4'hF); chk("w1c_irq_pre", {31'h0, irq0}, 32'h1);
    tick(); chk("w1c_irq_post", {31'h0, irq0}, 32'h0);
    pb[1] = 1'b1; idle(10);
    pb[1] = 1'b0; idle(6);
    bus_wr(2, 32'h2, 4'hF); chk("setwin_irq_pre", {31'h0, irq0}, 32'h0);
    tick(); chk("setwin_irq", {31'h0, irq0}, 32'h1);
    tick(); chk("setwin_irq_hold", {31'h0, irq0}, 32'h1);
    bus_rd(2); chk("setwin_cap", rd0, 32'h2);
    bus_wr(1, 32'h0, 4'hF);
    for (int i = 0; i < 19; i++) begin
      addr = tbl[i].a; wr = tbl[i].w; rd = tbl[i].r; wdata = tbl[i].d; be = tbl[i].b;
      tick();
      wr = 1'b0; rd = 1'b0;
      chk($sformatf("tbl%0d_out", i), out0, tbl[i].eo);
      chk($sformatf("tbl%0d_rdata", i), rd0, tbl[i].er);
    end
    chk("tbl_irq", {31'h0, irq0}, 32'h1);
    pb[1] = 1'b1; idle(10);
    chk("release_irq", {31'h0, irq0}, 32'h1);
    pb[3] = 1'b0; addr = 3'd3; rd = 1'b1; idle(4); rd = 1'b0;
    chk("pre_rst_rdata", rd0, 32'hFFFFFFFF);
    reset = 1'b1; pb = 4'hF;
    #1;
    chk("async_rst_out", out0, 32'h0);
    chk("async_rst_irq", {31'h0, irq0}, 32'h0);
    chk("async_rst_rdata", rd0, 32'h0);
    @(negedge clk); idle(1);
    reset = 1'b0;
    idle(15);
    bus_rd(2); chk("post_rst_cap", rd0, 32'h0);
    bus_rd(0); chk("post_rst_data", rd0, 32'h0);
    chk("post_rst_irq", {31'h0, irq0}, 32'h0);
    pb[0] = 1'b0; idle(10);
    bus_rd(2);
    chk("press_mode0", rd0, 32'h1);
    chk("press_mode1", rd1, 32'h0);
    chk("press_mode2", rd2, 32'h1);
    bus_wr(2, 32'hF, 4'hF);
    pb[0] = 1'b1; idle(10);
    bus_rd(2);
    chk("release_mode0", rd0, 32'h0);
    chk("release_mode1", rd1, 32'h1);
    chk("release_mode2", rd2, 32'h1);
    reset = 1'b1; idle(2); reset = 1'b0; mchk = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(7) == 0) begin
        k = $urandom_range(3);
        pb[k] = ~pb[k];
      end
      rd = 1'($urandom_range(1));
      wr = $urandom_range(2) == 0;
      addr = 3'($urandom_range(7));
      wdata = $urandom;
      be = 4'($urandom_range(15));
      tick();
    end
    rd = 1'b0; wr = 1'b0; mchk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/avalon_button_led_pio.md
Name: avalon_button_led_pio

Overview:
- Parametrised Avalon-MM slave peripheral for the HPS/FPGA system. Successor to the bare pushbutton-export and to_hex_to_led readdata pair.
- Input side: synchronises and debounces N_BUTTONS pushbuttons, captures press/release edges into a write-1-to-clear register, and raises a maskable level interrupt.
- Output side: holds an OUT_WIDTH-bit register driving the hex/LED decode logic, with byte-enabled write plus atomic set/clear aliases.

Parameters:
N_BUTTONS, 4, number of pushbutton channels (1..32)
OUT_WIDTH, 32, width of hex/LED output register (1..32)
DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles before a debounced level changes (>=2)
BUTTON_ACTIVE_LOW, 1, 1 = raw input 0 means pressed (DE1-SoC KEY)
EDGE_MODE, 0, 0 = capture press, 1 = capture release, 2 = both
OUT_RESET_VALUE, 0, reset value of output register

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
avs_address  in  3  word address
avs_read  in  1  read strobe
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_byteenable  in  4  byte lanes for writes
avs_readdata  out  32  read data, fixed read latency 1
pushbutton_in  in  N_BUTTONS  raw asynchronous button pins
to_hex_to_led  out  OUT_WIDTH  output register contents
irq  out  1  level interrupt, active high

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-high, named reset. All flops clear on reset assertion.
- Reset values:
  - avs_readdata = 0, irq = 0, to_hex_to_led = OUT_RESET_VALUE.
  - Edge-capture register = 0, irq mask = 0.
  - Debounced levels = "not pressed". Synchronisers and counters = 0.
- Input path, per channel:
  - 2-flop synchroniser, then invert if BUTTON_ACTIVE_LOW, giving "pressed" = 1.
  - Counter width = clog2(DEBOUNCE_CYCLES+1).
  - Counter resets to 0 whenever the synchronised value equals the debounced level. Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronised value and the counter returns to 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the debounced level.
  - Raw-pin-to-debounced latency = 2 + DEBOUNCE_CYCLES cycles.
- Edge capture:
  - An edge is a change of debounced level matching EDGE_MODE. It sets the corresponding capture bit one cycle after the level change.
  - Capture bits are sticky until cleared by writing 1 to that bit of EDGE_CAP.
  - Same-cycle edge set and W1C on the same bit: set wins, bit stays 1.
- irq: registered, irq = OR(edge_cap & irq_mask). It asserts 1 cycle after a capture bit or mask bit sets, and deasserts 1 cycle after clear.
- Register map (word addresses):
  - 0 DATA (RO): debounced levels in bits [N_BUTTONS-1:0], upper bits read 0. Writes ignored.
  - 1 IRQ_MASK (RW): bits [N_BUTTONS-1:0], byte-enabled.
  - 2 EDGE_CAP (R/W1C): byte-enabled W1C.
  - 3 OUT (RW): byte-enabled write of the output register, readback of the full value zero-extended.
  - 4 OUT_SET (WO): out |= writedata, ignoring byteenable. Reads 0.
  - 5 OUT_CLR (WO): out &= ~writedata, ignoring byteenable. Reads 0.
  - 6, 7: reserved. Read 0, writes ignored.
- Bus timing and conflicts:
  - Writes take effect at the clock edge where avs_write=1. to_hex_to_led updates 0 cycles after that edge (registered output).
  - Reads: avs_readdata is valid the cycle after avs_read=1, and holds its value until the next read.
  - A read in the same cycle as a write to the same register returns the pre-write value.
  - avs_read and avs_write both high: the write is performed, and readdata reflects the pre-write value.
- Unused bits: bits above N_BUTTONS and above OUT_WIDTH are write-ignored and read 0.
- Reset mid-debounce: counters clear, and no edge is captured for the aborted transition.
- No wait-request: every access completes in one cycle.

Test Plan:
- DEBOUNCE_CYCLES=4, reset released, pushbutton_in=4'hF held -> DATA reads 0, EDGE_CAP reads 0, irq=0, to_hex_to_led=0.
- Drive pushbutton_in[1]=0 for 3 cycles then back to 1 -> DATA stays 0, EDGE_CAP stays 0 (glitch rejected). Hold low 10 cycles -> DATA=4'h2 exactly 6 cycles after the pin falls, EDGE_CAP=4'h2 one cycle later.
- IRQ_MASK=4'h2 with EDGE_CAP=4'h2 -> irq=1 next cycle. Write EDGE_CAP=4'h2 -> irq=0 one cycle after the bit clears. Write EDGE_CAP=4'h2 in the same cycle a new press edge on bit 1 arrives -> bit remains 1, irq stays 1.
- Write OUT=32'h12345678 with byteenable=4'b0100 over a reset value of 0 -> to_hex_to_led=32'h00340000. Then OUT_SET=32'h0000000F -> 32'h0034000F. Then OUT_CLR=32'h00300000 -> 32'h0004000F. Read address 3 -> 32'h0004000F one cycle later.
- EDGE_MODE=2: press then release on button 0, clear EDGE_CAP between them -> EDGE_CAP bit 0 sets on both transitions. EDGE_MODE=1: press alone -> EDGE_CAP stays 0.
- Assert reset while button 3's counter is at 2 and OUT=32'hFFFFFFFF -> all registers return to reset values immediately (asynchronously), irq=0, and no edge is captured after reset release.
